// File: rtl/universal_shift_reg_if.sv
// Bus bundle for the universal shift register: control, serial/parallel data in,
// and the registered contents with their serial and counter decodes out.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  logic [1:0]       mode;
  logic             sin_msb;
  logic             sin_lsb;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    cnt;
  logic             full;

  modport master (
    output en, mode, sin_msb, sin_lsb, pin,
    input  q, sout_r, sout_l, cnt, full
  );

  modport slave (
    input  en, mode, sin_msb, sin_lsb, pin,
    output q, sout_r, sout_l, cnt, full
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, bidirectional serial shift, parallel load, with a
// saturating shift counter that flags a complete word shifted since the last load.
module universal_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input logic                  clk,
  input logic                  rst_n,
  universal_shift_reg_if.slave bus
);
  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } modeE;

  logic [WIDTH-1:0] qReg;
  logic [CW-1:0]    cntReg;
  logic             cntSat;

  assign cntSat = (cntReg == CNT_MAX);

  // Reset wins over enable, which wins over mode; holding never samples the data inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qReg   <= RESET_VAL;
      cntReg <= '0;
    end else if (bus.en) begin
      case (modeE'(bus.mode))
        MODE_HOLD: begin
          qReg   <= qReg;
          cntReg <= cntReg;
        end
        MODE_RIGHT: begin
          qReg   <= {bus.sin_msb, qReg[WIDTH-1:1]};
          cntReg <= cntSat ? cntReg : cntReg + 1'b1;
        end
        MODE_LEFT: begin
          qReg   <= {qReg[WIDTH-2:0], bus.sin_lsb};
          cntReg <= cntSat ? cntReg : cntReg + 1'b1;
        end
        MODE_LOAD: begin
          qReg   <= bus.pin;
          cntReg <= '0;
        end
      endcase
    end
  end

  // All outputs are decodes of registered state only.
  assign bus.q      = qReg;
  assign bus.cnt    = cntReg;
  assign bus.full   = cntSat;
  assign bus.sout_r = qReg[0];
  assign bus.sout_l = qReg[WIDTH-1];
endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg at WIDTH=8: a vector table of single-edge
// operations plus serial-in/serial-out sequences checked bit by bit.
module tb_universal_shift_reg;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  universal_shift_reg_if #(.WIDTH(WIDTH)) bus ();

  universal_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic       rstN;
    logic       en;
    logic [1:0] mode;
    logic       sinMsb;
    logic       sinLsb;
    logic [7:0] pin;
    logic [7:0] expQ;
    logic [3:0] expCnt;
    logic       expFull;
    logic       expSoutR;
    logic       expSoutL;
  } vecT;

  vecT vecs[$];

  task automatic applyStimulus(input logic rstN, input logic en, input logic [1:0] mode,
                               input logic sinMsb, input logic sinLsb, input logic [7:0] pin);
    rst_n       = rstN;
    bus.en      = en;
    bus.mode    = mode;
    bus.sin_msb = sinMsb;
    bus.sin_lsb = sinLsb;
    bus.pin     = pin;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison covers the whole visible state so a single line shows every field.
  task automatic checkOutput(input string name, input logic [7:0] expQ, input logic [3:0] expCnt,
                             input logic expFull, input logic expSoutR, input logic expSoutL);
    checks++;
    if (bus.q !== expQ || bus.cnt !== expCnt || bus.full !== expFull ||
        bus.sout_r !== expSoutR || bus.sout_l !== expSoutL) begin
      errors++;
      $display("[TB] FAIL %s: got q=%h cnt=%0d full=%b sr=%b sl=%b, want q=%h cnt=%0d full=%b sr=%b sl=%b",
               name, bus.q, bus.cnt, bus.full, bus.sout_r, bus.sout_l,
               expQ, expCnt, expFull, expSoutR, expSoutL);
    end
  endtask

  task automatic checkBit(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got %b, want %b", name, idx, act, exp);
    end
  endtask

  task automatic addVec(input string name, input logic rstN, input logic en, input logic [1:0] mode,
                        input logic sinMsb, input logic sinLsb, input logic [7:0] pin,
                        input logic [7:0] expQ, input logic [3:0] expCnt, input logic expFull,
                        input logic expSoutR, input logic expSoutL);
    vecT v;
    v.name = name; v.rstN = rstN; v.en = en; v.mode = mode;
    v.sinMsb = sinMsb; v.sinLsb = sinLsb; v.pin = pin;
    v.expQ = expQ; v.expCnt = expCnt; v.expFull = expFull;
    v.expSoutR = expSoutR; v.expSoutL = expSoutL;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] sisoBits;
    logic [7:0] leftWord;

    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hFF);

    //      name          rst en mode  smsb slsb pin     q     cnt full sr  sl
    addVec("reset1",     0, 1, 2'b11, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 0);
    addVec("reset2",     0, 1, 2'b11, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 0);
    addVec("loadA5",     1, 1, 2'b11, 0, 0, 8'hA5, 8'hA5, 0, 0, 1, 1);
    addVec("hold1",      1, 1, 2'b00, 1, 1, 8'h3C, 8'hA5, 0, 0, 1, 1);
    addVec("hold2",      1, 1, 2'b00, 1, 1, 8'h3C, 8'hA5, 0, 0, 1, 1);
    addVec("hold3",      1, 1, 2'b00, 1, 1, 8'h3C, 8'hA5, 0, 0, 1, 1);
    addVec("enLow1",     1, 0, 2'b01, 1, 1, 8'h3C, 8'hA5, 0, 0, 1, 1);
    addVec("enLow2",     1, 0, 2'b11, 1, 1, 8'h3C, 8'hA5, 0, 0, 1, 1);
    addVec("shr1",       1, 1, 2'b01, 0, 0, 8'h00, 8'h52, 1, 0, 0, 0);
    addVec("shr2",       1, 1, 2'b01, 0, 0, 8'h00, 8'h29, 2, 0, 1, 0);
    addVec("shr3",       1, 1, 2'b01, 0, 0, 8'h00, 8'h14, 3, 0, 0, 0);
    addVec("shr4",       1, 1, 2'b01, 0, 0, 8'h00, 8'h0A, 4, 0, 0, 0);
    addVec("shr5",       1, 1, 2'b01, 0, 0, 8'h00, 8'h05, 5, 0, 1, 0);
    addVec("shr6",       1, 1, 2'b01, 0, 0, 8'h00, 8'h02, 6, 0, 0, 0);
    addVec("shr7",       1, 1, 2'b01, 0, 0, 8'h00, 8'h01, 7, 0, 1, 0);
    addVec("shr8full",   1, 1, 2'b01, 0, 0, 8'h00, 8'h00, 8, 1, 0, 0);
    addVec("shr9sat",    1, 1, 2'b01, 0, 0, 8'h00, 8'h00, 8, 1, 0, 0);
    addVec("shr10sat",   1, 1, 2'b01, 0, 0, 8'h00, 8'h00, 8, 1, 0, 0);
    addVec("freezeSat",  1, 0, 2'b01, 1, 0, 8'h00, 8'h00, 8, 1, 0, 0);
    addVec("loadWhenFull",1,1, 2'b11, 0, 0, 8'h81, 8'h81, 0, 0, 1, 1);
    addVec("shl1",       1, 1, 2'b10, 0, 1, 8'h00, 8'h03, 1, 0, 1, 0);
    addVec("dirChange",  1, 1, 2'b01, 1, 0, 8'h00, 8'h81, 2, 0, 1, 1);
    addVec("loadFF",     1, 1, 2'b11, 0, 0, 8'hFF, 8'hFF, 0, 0, 1, 1);
    addVec("midShr1",    1, 1, 2'b01, 0, 0, 8'h00, 8'h7F, 1, 0, 1, 0);
    addVec("midShr2",    1, 1, 2'b01, 0, 0, 8'h00, 8'h3F, 2, 0, 1, 0);
    addVec("midShr3",    1, 1, 2'b01, 0, 0, 8'h00, 8'h1F, 3, 0, 1, 0);
    addVec("midReset",   0, 1, 2'b01, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0);
    addVec("load5A",     1, 1, 2'b11, 0, 0, 8'h5A, 8'h5A, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].en, vecs[i].mode, vecs[i].sinMsb, vecs[i].sinLsb, vecs[i].pin);
      tick();
      checkOutput(vecs[i].name, vecs[i].expQ, vecs[i].expCnt, vecs[i].expFull,
                  vecs[i].expSoutR, vecs[i].expSoutL);
    end

    // SISO deserialise then serialise back out through sout_r.
    sisoBits = 8'b1100_1101;
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
    tick();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b01, sisoBits[i], 1'b0, 8'h00);
      tick();
    end
    checkOutput("sisoWord", 8'hCD, 4'd8, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
      checkBit("sisoOut", i, bus.sout_r, sisoBits[i]);
      tick();
    end
    checkOutput("sisoDrained", 8'h00, 4'd8, 1'b1, 1'b0, 1'b0);

    // Left-shift serialise: MSB first on sout_l, and cnt saturates the same way.
    leftWord = 8'h96;
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, leftWord);
    tick();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
      checkBit("leftOut", i, bus.sout_l, leftWord[7-i]);
      tick();
    end
    checkOutput("leftDrained", 8'h00, 4'd8, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register. It is the successor to the fixed single-bit serial-in/serial-out shifter. It supports configurable width, hold, bidirectional serial shift, parallel load and parallel readout. A saturating shift counter flags when a full word has been shifted since the last load, so the block also serves as a serialiser or deserialiser in front of byte-oriented logic.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range ≥ 2.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into `q` on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low; overrides every other input.
- en  in  1  operation enable; when low, all state holds.
- mode  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_msb  in  1  serial input; enters `q[WIDTH-1]` on a right shift.
- sin_lsb  in  1  serial input; enters `q[0]` on a left shift.
- pin  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents (registered).
- sout_r  out  1  right-shift serial output, equal to `q[0]`.
- sout_l  out  1  left-shift serial output, equal to `q[WIDTH-1]`.
- cnt  out  $clog2(WIDTH+1)  number of shifts since the last load or reset, saturating at WIDTH.
- full  out  1  high when `cnt == WIDTH`.

## Operation
- Priority per rising edge:
  - `rst_n == 0`: reset.
  - else `en == 0`: hold.
  - else the operation selected by `mode`.
- Reset: `q <= RESET_VAL`, `cnt <= 0`. Hence `full = 0`, `sout_r = RESET_VAL[0]`, `sout_l = RESET_VAL[WIDTH-1]`.
- Hold (mode 00, or en low): `q` and `cnt` unchanged.
- Shift right (01): `q <= {sin_msb, q[WIDTH-1:1]}`. The bit in `q[0]` is discarded after being presented on `sout_r`.
- Shift left (10): `q <= {q[WIDTH-2:0], sin_lsb}`. The bit in `q[WIDTH-1]` is discarded after being presented on `sout_l`.
- Parallel load (11): `q <= pin`, `cnt <= 0`.
- Every shift in either direction increments `cnt`, saturating at WIDTH. Further shifts leave `cnt = WIDTH` and `full = 1`.
- Direction changes do not clear `cnt`; only load or reset clears it.
- Single-ended SISO behaviour: mode 01 with `en = 1`, input on `sin_msb`, output on `sout_r`.
- `sout_r`, `sout_l` and `full` are pure decodes of registered state. There is no combinational path from any input to any output.
- No X propagation from `pin`, `sin_msb` or `sin_lsb` into `q` while holding.

## Timing
- `q`, `cnt` and `full` change only on the rising edge of `clk`.
- Parallel load: latency 1 cycle (`pin` is visible on `q` after the edge).
- Serial: a bit applied to `sin_msb` before edge k appears on `sout_r` after edge k+WIDTH-1, i.e. WIDTH shift edges from input to discard. The same applies to `sin_lsb` and `sout_l`.
- `full` rises on the edge of the WIDTH-th shift after a load or reset. It stays high until the next load or reset.
- Reset mid-operation: the edge with `rst_n` low discards any shift or load in progress, regardless of `en` and `mode`. Normal operation resumes on the first edge with `rst_n` high.
- Load arriving while `full = 1`: `full` is low after that edge.
- `en` low freezes `cnt`, including at saturation.

## Test plan
Conditions: WIDTH = 8, RESET_VAL = 0.
- Reset: `rst_n = 0` for 2 edges with `en = 1`, `mode = 11`, `pin = 8'hFF` -> `q = 8'h00`, `cnt = 0`, `full = 0`, `sout_r = sout_l = 0`.
- Load and hold: load `8'hA5`, then `mode = 00` for 3 edges -> `q = 8'hA5`, `cnt = 0` throughout. Repeat with `en = 0` and `mode = 01` -> still `8'hA5`.
- Right-shift serialise: load `8'hA5`, `mode = 01`, `sin_msb = 0` for 10 edges.
  - `sout_r` before each of the first 8 edges: 1,0,1,0,0,1,0,1.
  - `q = 8'h00` after edge 8.
  - `full` is high from edge 8 on; `cnt` stays 8 on edges 9 and 10.
- SISO deserialise: after reset, drive `sin_msb` with 1,0,1,1,0,0,1,1 on 8 consecutive right shifts.
  - `q = 8'hCD` and `full = 1` after the 8th edge.
  - 8 further shifts with `sin_msb = 0` give `sout_r` = 1,0,1,1,0,0,1,1.
- Left shift and direction change:
  - Load `8'h81`, one left shift with `sin_lsb = 1` -> `q = 8'h03`, `cnt = 1`, `sout_l` goes 1 -> 0.
  - One right shift with `sin_msb = 1` -> `q = 8'h81`, `cnt = 2`.
- Reset mid-shift: 3 right shifts from `8'hFF`, then `rst_n = 0` with `en = 1`, `mode = 01` -> `q = 8'h00`, `cnt = 0` after that edge. A load of `8'h5A` on the next edge with `rst_n = 1` -> `q = 8'h5A`.
